ps2_key_rx: RTL

Receives PS/2 keyboard frames from the raw `ps2_clk`/`ps2_data` pins and decodes make/break/extended prefixes. It delivers each key event as the 11-bit `ps2_key` word consumed by the ZX81 top-level keyboard matrix. It sits directly upstream of `fpga_zx81` on the `clk_sys` domain and replaces the vendor PS/2 core.

---
 rtl/ps2_pkg.sv | 37 +++
 rtl/ps2_key_rx_if.sv | 27 ++
 rtl/ps2_filter.sv | 38 +++
 rtl/ps2_key_rx.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: FSM states,
// prefix codes, the discard-code list and ps2_key field positions.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam int PS2_KEY_W = 11;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Keyboard replies (ACK, BAT ok, echo, resend) and error codes carry no key
    localparam int                           PS2_DISCARD_NUM  = 6;
    localparam logic [PS2_DISCARD_NUM*8-1:0] PS2_DISCARD_LIST =
        {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    localparam int KEY_TOGGLE  = 10;
    localparam int KEY_PRESSED = 9;
    localparam int KEY_EXT     = 8;

    function automatic logic is_discard(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < PS2_DISCARD_NUM; i++) begin
            if (PS2_DISCARD_LIST[i*8 +: 8] == code) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_key_rx_if.sv
// Pin and key-event bundle between the PS/2 pins and the keyboard matrix.
interface ps2_key_rx_if;
    import ps2_pkg::*;

    logic                 ps2_clk;
    logic                 ps2_data;
    logic [PS2_KEY_W-1:0] ps2_key;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  ps2_key,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output ps2_key,
        output frame_err,
        output busy
    );

endinterface

// File: rtl/ps2_filter.sv
// Two-flop synchronizer followed by a glitch filter: the output level only
// follows the input after FILTER_LEN consecutive equal synchronized samples.
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic i_pin,
    output logic o_level
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], i_pin};
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: frames bytes off the pins and folds E0/F0 prefixes
// into ps2_key events. Define PS2_PARITY_CHECK_EN to reject bad-parity frames.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input logic          clk_sys,
    input logic          reset_n,
    ps2_key_rx_if.slave  bus
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic                 w_clk_f;
    logic                 w_data_f;
    logic                 w_fall;
    logic                 w_timeout;
    logic                 w_parity_ok;

    logic                 r_clk_prev;
    ps2_state_t           r_state,   w_state_next;
    logic [2:0]           r_bit_cnt, w_bit_cnt_next;
    logic [7:0]           r_shift,   w_shift_next;
    logic                 r_parity,  w_parity_next;
    logic                 r_ext,     w_ext_next;
    logic                 r_brk,     w_brk_next;
    logic [TW-1:0]        r_tmo,     w_tmo_next;
    logic [PS2_KEY_W-1:0] r_key,     w_key_next;
    logic                 r_err,     w_err_next;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_pin   (bus.ps2_clk),
        .o_level (w_clk_f)
    );

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_pin   (bus.ps2_data),
        .o_level (w_data_f)
    );

    assign w_fall    = r_clk_prev & ~w_clk_f;
    assign w_timeout = (r_state != IDLE) && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
    assign w_parity_ok = ^{r_shift, r_parity};
`else
    logic w_unused_parity;
    assign w_unused_parity = r_parity;
    assign w_parity_ok     = 1'b1;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;
        w_ext_next     = r_ext;
        w_brk_next     = r_brk;
        w_key_next     = r_key;
        w_err_next     = 1'b0;
        w_tmo_next     = (r_state == IDLE || w_fall) ? '0 : r_tmo + 1'b1;

        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    if (!w_data_f) begin
                        w_state_next   = DATA;
                        w_bit_cnt_next = 3'd0;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_fall) begin
                    w_shift_next   = {w_data_f, r_shift[7:1]};
                    w_bit_cnt_next = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (w_fall) begin
                    w_parity_next = w_data_f;
                    w_state_next  = STOP;
                end
            end
            STOP: begin
                if (w_fall) begin
                    w_state_next = IDLE;
                    if (w_data_f && w_parity_ok) begin
                        if (r_shift == PS2_EXT) begin
                            w_ext_next = 1'b1;
                        end else if (r_shift == PS2_BRK) begin
                            w_brk_next = 1'b1;
                        end else begin
                            // Prefixes only ever qualify the next real key
                            if (!is_discard(r_shift)) begin
                                w_key_next[KEY_TOGGLE]  = ~r_key[KEY_TOGGLE];
                                w_key_next[KEY_PRESSED] = ~r_brk;
                                w_key_next[KEY_EXT]     = r_ext;
                                w_key_next[7:0]         = r_shift;
                            end
                            w_ext_next = 1'b0;
                            w_brk_next = 1'b0;
                        end
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        if (w_timeout && !w_fall) begin
            w_state_next = IDLE;
            w_err_next   = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_prev <= 1'b1;
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
            r_tmo      <= '0;
            r_key      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_clk_prev <= w_clk_f;
            r_state    <= w_state_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
            r_parity   <= w_parity_next;
            r_ext      <= w_ext_next;
            r_brk      <= w_brk_next;
            r_tmo      <= w_tmo_next;
            r_key      <= w_key_next;
            r_err      <= w_err_next;
        end
    end

    assign bus.ps2_key   = r_key;
    assign bus.frame_err = r_err;
    assign bus.busy      = (r_state != IDLE);

endmodule
